// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types for the data-memory controller.
//   XLEN         - architectural address/data width
//   MEM_SIZE     - bus access size encoding
//   BUS_COMMAND  - proc2mem command encoding
//   DMEM_STATE   - load-side FSM states
//   SB_ENTRY     - one buffered, already-retired store
package dmem_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        BYTE   = 2'h0,
        HALF   = 2'h1,
        WORD   = 2'h2,
        DOUBLE = 2'h3
    } MEM_SIZE;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    typedef enum logic [1:0] {
        IDLE     = 2'h0,
        LD_WAIT  = 2'h1,
        LD_DRAIN = 2'h2
    } DMEM_STATE;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        MEM_SIZE         size;
        logic [XLEN-1:0] data;
    } SB_ENTRY;

endpackage

// File: rtl/dmem_ctrl_store_buffer.sv
// store_buffer: in-order FIFO of retired stores with a parallel line-address
// match port used to hold back loads that overlap a pending store.
//   clock, reset   - clock / async active-high reset
//   push, push_entry - enqueue a store (dropped if full and not popping)
//   pop            - dequeue the head (ignored when empty)
//   head_entry     - oldest buffered store
//   full, empty    - derived from the registered occupancy count
//   query_line     - 8-byte line address (addr[XLEN-1:3]) to match
//   hit            - some valid entry lies in query_line
module store_buffer
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4,
    parameter int unsigned SB_IDX_W = $clog2(SB_DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            push,
    input  SB_ENTRY         push_entry,
    input  logic            pop,
    output SB_ENTRY         head_entry,
    output logic            full,
    output logic            empty,
    input  logic [XLEN-4:0] query_line,
    output logic            hit
);

    SB_ENTRY               mem_q [SB_DEPTH];
    SB_ENTRY               mem_d [SB_DEPTH];
    logic [SB_IDX_W-1:0]   head_q, head_d;
    logic [SB_IDX_W-1:0]   tail_q, tail_d;
    logic [SB_IDX_W:0]     count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full       = (count_q == (SB_IDX_W+1)'(SB_DEPTH));
    assign empty      = (count_q == '0);
    assign head_entry = mem_q[head_q];

    // A push into a full buffer is still taken when the head leaves in the same
    // cycle: the freed slot is exactly the one tail points at.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + (SB_IDX_W+1)'(push_ok) - (SB_IDX_W+1)'(pop_ok);
        if (push_ok) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + SB_IDX_W'(1);
        end
        if (pop_ok) begin
            head_d = head_q + SB_IDX_W'(1);
        end
    end

    // Entry i is valid when its distance from head is below the count.
    always_comb begin
        hit = 1'b0;
        for (int unsigned i = 0; i < SB_DEPTH; i++) begin
            if (({1'b0, SB_IDX_W'(i) - head_q} < count_q) &&
                (mem_q[i].addr[XLEN-1:3] == query_line)) begin
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int unsigned i = 0; i < SB_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            mem_q   <= mem_d;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(push && full && !pop))
                else $error("store_buffer: push while full, store dropped");
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: arbitrates the single data-memory bus between buffered retired
// stores and one-at-a-time loads, and matches tagged load responses.
//   clock, reset        - clock / async active-high reset
//   st_*                - retire-stage store port; sb_full/sb_empty status
//   ld_valid/addr/size  - load request, held until ld_grant
//   ld_grant            - load accepted by memory this cycle
//   ld_done, ld_data    - one-cycle completion pulse with the returned line
//   flush               - abandon pending/outstanding load (stores unaffected)
//   proc2mem_*          - bus request; mem2proc_* - acceptance tag and completion
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned SB_DEPTH = 4,
    parameter int unsigned SB_IDX_W = $clog2(SB_DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  BUS_COMMAND      st_command,
    input  MEM_SIZE         st_size,
    input  logic [XLEN-1:0] st_addr,
    input  logic [XLEN-1:0] st_data,
    output logic            sb_full,
    output logic            sb_empty,
    input  logic            ld_valid,
    input  logic [XLEN-1:0] ld_addr,
    input  MEM_SIZE         ld_size,
    output logic            ld_grant,
    output logic            ld_done,
    output logic [63:0]     ld_data,
    input  logic            flush,
    output BUS_COMMAND      proc2mem_command,
    output logic [XLEN-1:0] proc2mem_addr,
    output MEM_SIZE         proc2mem_size,
    output logic [63:0]     proc2mem_data,
    input  logic [3:0]      mem2proc_response,
    input  logic [63:0]     mem2proc_data,
    input  logic [3:0]      mem2proc_tag
);

    DMEM_STATE  state_q, state_d;
    logic [3:0] tag_q, tag_d;
    SB_ENTRY    head;
    SB_ENTRY    push_entry;
    logic       push, pop, line_hit;
    logic       load_ok, sel_store, sel_load, accepted;

    assign push       = (st_command == BUS_STORE);
    assign push_entry = '{addr: st_addr, size: st_size, data: st_data};

    store_buffer #(
        .SB_DEPTH (SB_DEPTH),
        .SB_IDX_W (SB_IDX_W)
    ) u_sb (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head_entry (head),
        .full       (sb_full),
        .empty      (sb_empty),
        .query_line (ld_addr[XLEN-1:3]),
        .hit        (line_hit)
    );

    // Bus arbitration: a full buffer forces the store head out first so
    // retire can make progress; otherwise loads win over background drain.
    always_comb begin
        load_ok   = (state_q == IDLE) && ld_valid && !flush && !line_hit;
        sel_store = 1'b0;
        sel_load  = 1'b0;
        if (!reset) begin
            if (sb_full) begin
                sel_store = 1'b1;
            end else if (load_ok) begin
                sel_load = 1'b1;
            end else if (!sb_empty) begin
                sel_store = 1'b1;
            end
        end
        accepted = (mem2proc_response != 4'h0);

        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_size    = BYTE;
        proc2mem_data    = '0;
        if (sel_store) begin
            proc2mem_command = BUS_STORE;
            proc2mem_addr    = head.addr;
            proc2mem_size    = head.size;
            proc2mem_data    = 64'(head.data);
        end else if (sel_load) begin
            proc2mem_command = BUS_LOAD;
            proc2mem_addr    = ld_addr;
            proc2mem_size    = ld_size;
        end

        pop      = sel_store && accepted;
        ld_grant = sel_load && accepted;
    end

    // Load FSM. The saved tag is never 0 because only a nonzero response
    // counts as acceptance, so a tag of 0 on the bus can never match.
    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        ld_done = 1'b0;
        ld_data = '0;
        unique case (state_q)
            IDLE: begin
                if (ld_grant) begin
                    state_d = LD_WAIT;
                    tag_d   = mem2proc_response;
                end
            end
            LD_WAIT: begin
                if (mem2proc_tag == tag_q) begin
                    state_d = IDLE;
                    if (!flush) begin
                        ld_done = 1'b1;
                        ld_data = mem2proc_data;
                    end
                end else if (flush) begin
                    state_d = LD_DRAIN;
                end
            end
            LD_DRAIN: begin
                if (mem2proc_tag == tag_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
        end
    end

endmodule
